// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, issues one BRAM word read per fetch request and
// returns the word with its PC as a one-cycle valid pulse. PC faults latch into sticky flags.
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 14,
  parameter int          MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   fetch_req,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic                   inst_valid,
  output logic [31:0]            inst_code,
  output logic [31:0]            inst_pc,
  output logic                   busy,
  output logic                   err_misalign,
  output logic                   err_range,
  output logic                   err_overlap,
  output logic [31:0]            fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  state_t                 state_q;
  logic [31:0]            pc_q, fpc_q;
  logic [2:0]             wait_cnt_q;
  logic                   imem_en_q, inst_valid_q, busy_q;
  logic [IMEM_ADDR_W-1:0] imem_addr_q;
  logic [31:0]            inst_code_q, inst_pc_q, fetch_count_q;
  logic                   err_misalign_q, err_range_q, err_overlap_q;

  logic        redir_ok, redir_bad, any_err, can_start, in_range;
  logic [31:0] fpc_d;

  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign any_err   = err_misalign_q | err_range_q | err_overlap_q;
  assign fpc_d     = redir_ok ? redirect_pc : pc_q;
  assign in_range  = ((fpc_d >> (IMEM_ADDR_W + 2)) == 32'd0);
  // The capture cycle already has its instruction out, so it can accept the next request.
  assign can_start = ((state_q == S_IDLE) || (state_q == S_CAPTURE)) && fetch_req &&
                     !any_err && !redir_bad;

  // NOTE: every register here uses <= so all of them see the same pre-edge values,
  // and a later assignment in this block overrides an earlier one on the same edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      fpc_q          <= RESET_PC;
      wait_cnt_q     <= 3'd0;
      imem_en_q      <= 1'b0;
      imem_addr_q    <= '0;
      inst_valid_q   <= 1'b0;
      inst_code_q    <= 32'd0;
      inst_pc_q      <= 32'd0;
      busy_q         <= 1'b0;
      fetch_count_q  <= 32'd0;
      err_misalign_q <= 1'b0;
      err_range_q    <= 1'b0;
      err_overlap_q  <= 1'b0;
    end else begin
      imem_en_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      if (redir_ok)  pc_q           <= redirect_pc;
      if (redir_bad) err_misalign_q <= 1'b1;

      case (state_q)
        S_IDLE, S_CAPTURE: begin
          state_q <= S_IDLE;
          if (can_start) begin
            fpc_q <= fpc_d;
            if (!in_range) begin
              err_range_q <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              imem_en_q   <= 1'b1;
              imem_addr_q <= fpc_d[IMEM_ADDR_W+1:2];
              busy_q      <= 1'b1;
              // Advancing the PC at issue lets any redirect during the flight simply overwrite it.
              pc_q        <= fpc_d + 32'd4;
            end
          end
        end
        S_ISSUE: begin
          if (fetch_req) err_overlap_q <= 1'b1;
          wait_cnt_q <= 3'(MEM_LATENCY);
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (fetch_req) err_overlap_q <= 1'b1;
          if (wait_cnt_q == 3'd1) begin
            inst_code_q   <= imem_rdata;
            inst_pc_q     <= fpc_q;
            inst_valid_q  <= 1'b1;
            fetch_count_q <= fetch_count_q + 32'd1;
            busy_q        <= 1'b0;
            state_q       <= S_CAPTURE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_en      = imem_en_q;
  assign imem_addr    = imem_addr_q;
  assign inst_valid   = inst_valid_q;
  assign inst_code    = inst_code_q;
  assign inst_pc      = inst_pc_q;
  assign busy         = busy_q;
  assign err_misalign = err_misalign_q;
  assign err_range    = err_range_q;
  assign err_overlap  = err_overlap_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a one-cycle BRAM model on the default instance and a
// small-memory instance for the range fault. Inputs change and outputs are sampled at negedge.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance
  logic        fetch_req, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid, busy, err_misalign, err_range, err_overlap;
  logic [31:0] inst_code, inst_pc, fetch_count;

  inst_fetch dut (
    .clk(clk), .rstn(rstn), .fetch_req(fetch_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_code(inst_code),
    .inst_pc(inst_pc), .busy(busy), .err_misalign(err_misalign), .err_range(err_range),
    .err_overlap(err_overlap), .fetch_count(fetch_count)
  );

  logic [31:0] mem [0:63];
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr[5:0]];

  // Small-memory instance: 16 words, byte range 0x00..0x3F
  logic        f2_req, r2_valid;
  logic [31:0] r2_pc;
  logic        en2;
  logic [3:0]  addr2;
  logic        valid2, busy2, mis2, rng2, ovl2;
  logic [31:0] code2, pc2, cnt2;
  int          en2_pulses = 0;

  inst_fetch #(.IMEM_ADDR_W(4)) dut2 (
    .clk(clk), .rstn(rstn), .fetch_req(f2_req), .redirect_valid(r2_valid),
    .redirect_pc(r2_pc), .imem_en(en2), .imem_addr(addr2), .imem_rdata(32'd0),
    .inst_valid(valid2), .inst_code(code2), .inst_pc(pc2), .busy(busy2),
    .err_misalign(mis2), .err_range(rng2), .err_overlap(ovl2), .fetch_count(cnt2)
  );

  always @(posedge clk) if (en2) en2_pulses <= en2_pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h0050_0093;
    fetch_req = 0; redirect_valid = 0; redirect_pc = 0;
    f2_req = 0; r2_valid = 0; r2_pc = 0;
    @(negedge clk);

    // Reset state
    rstn = 1'b0;
    tick(2);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_en", 32'(imem_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_code", inst_code, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_errs", {29'd0, err_misalign, err_range, err_overlap}, 32'd0);
    rstn = 1'b1;

    // 1: single fetch from reset PC
    fetch_req = 1; tick(); fetch_req = 0;
    check("t1_en", 32'(imem_en), 32'd1);
    check("t1_addr", 32'(imem_addr), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_en_pulse", 32'(imem_en), 32'd0);
    check("t1_early_valid", 32'(inst_valid), 32'd0);
    tick();
    check("t1_valid", 32'(inst_valid), 32'd1);
    check("t1_code", inst_code, 32'h0050_0093);
    check("t1_pc", inst_pc, 32'd0);
    check("t1_count", fetch_count, 32'd1);
    tick();
    check("t1_valid_pulse", 32'(inst_valid), 32'd0);
    check("t1_code_hold", inst_code, 32'h0050_0093);

    // 2: back-to-back fetches from 0, each next request in the inst_valid cycle
    fetch_req = 1; redirect_valid = 1; redirect_pc = 32'h0;
    tick(); fetch_req = 0; redirect_valid = 0;
    check("t2_addr0", 32'(imem_addr), 32'd0);
    tick(2);
    check("t2_v0", 32'(inst_valid), 32'd1);
    check("t2_pc0", inst_pc, 32'h0);
    fetch_req = 1; tick(); fetch_req = 0;
    check("t2_gap0", 32'(inst_valid), 32'd0);
    check("t2_en1", 32'(imem_en), 32'd1);
    check("t2_addr1", 32'(imem_addr), 32'd1);
    tick(2);
    check("t2_pc1", inst_pc, 32'h4);
    check("t2_code1", inst_code, 32'hA000_0001);
    fetch_req = 1; tick(); fetch_req = 0;
    check("t2_gap1", 32'(inst_valid), 32'd0);
    tick(2);
    check("t2_v2", 32'(inst_valid), 32'd1);
    check("t2_pc2", inst_pc, 32'h8);
    check("t2_code2", inst_code, 32'hA000_0002);
    tick();
    check("t2_gap2", 32'(inst_valid), 32'd0);
    check("t2_count", fetch_count, 32'd4);
    check("t2_overlap", 32'(err_overlap), 32'd0);

    // 3: redirect during WAIT, then redirect coinciding with CAPTURE
    do_reset();
    fetch_req = 1; tick(); fetch_req = 0;
    tick();
    redirect_valid = 1; redirect_pc = 32'h40; tick(); redirect_valid = 0;
    check("t3_inflight_pc", inst_pc, 32'h0);
    check("t3_inflight_code", inst_code, 32'h0050_0093);
    tick();
    fetch_req = 1; tick(); fetch_req = 0;
    check("t3_addr", 32'(imem_addr), 32'd16);
    tick(2);
    check("t3_redir_pc", inst_pc, 32'h40);
    check("t3_redir_code", inst_code, 32'hA000_0010);
    redirect_valid = 1; redirect_pc = 32'h40; tick(); redirect_valid = 0;
    fetch_req = 1; tick(); fetch_req = 0;
    tick(2);
    check("t3_cap_redir_pc", inst_pc, 32'h40);

    // 6: reset during WAIT aborts the fetch
    do_reset();
    fetch_req = 1; tick(); fetch_req = 0;
    tick();
    rstn = 1'b0; tick();
    check("t6_valid", 32'(inst_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_code", inst_code, 32'd0);
    check("t6_count", fetch_count, 32'd0);
    tick(); rstn = 1'b1;
    check("t6_late_valid", 32'(inst_valid), 32'd0);
    fetch_req = 1; tick(); fetch_req = 0;
    tick(2);
    check("t6_refetch_valid", 32'(inst_valid), 32'd1);
    check("t6_refetch_pc", inst_pc, 32'h0);
    check("t6_refetch_count", fetch_count, 32'd1);

    // Overlap: request held into ISSUE sets err_overlap, current fetch still completes
    tick();
    fetch_req = 1; tick(); tick(); fetch_req = 0;
    check("ovl_flag", 32'(err_overlap), 32'd1);
    tick();
    check("ovl_completes", 32'(inst_valid), 32'd1);
    check("ovl_pc", inst_pc, 32'h4);
    tick();
    fetch_req = 1; tick(); fetch_req = 0;
    check("ovl_blocked_en", 32'(imem_en), 32'd0);
    check("ovl_blocked_busy", 32'(busy), 32'd0);

    // 4: misaligned redirect is sticky until reset
    do_reset();
    redirect_valid = 1; redirect_pc = 32'h42; tick(); redirect_valid = 0;
    check("t4_misalign", 32'(err_misalign), 32'd1);
    fetch_req = 1; tick(); fetch_req = 0;
    check("t4_en", 32'(imem_en), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t4_no_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    do_reset();
    check("t4_cleared", 32'(err_misalign), 32'd0);

    // 5: out-of-range fetch on the 16-word instance
    r2_valid = 1; r2_pc = 32'h40; tick(); r2_valid = 0;
    f2_req = 1; tick(); f2_req = 0;
    check("t5_range", 32'(rng2), 32'd1);
    check("t5_en", 32'(en2), 32'd0);
    tick(3);
    check("t5_busy", 32'(busy2), 32'd0);
    check("t5_valid", 32'(valid2), 32'd0);
    check("t5_en_pulses", 32'(en2_pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
